// File: rtl/jtbubl_rom_slot.sv
// Graphics ROM slot: fetches a 32-bit pair of 16-bit SDRAM words per request
// and holds the last pair so a repeated address is served without SDRAM access.
module jtbubl_rom_slot #(
   parameter logic [21:0] BASE  = 22'h0,
   parameter bit          LATCH = 1'b1
)(
   input  logic        clk,
   input  logic        rst,
   input  logic        rom_cs,
   input  logic [17:0] rom_addr,
   output logic [31:0] rom_data,
   output logic        rom_ok,
   output logic        sdram_req,
   output logic [21:0] sdram_addr,
   input  logic        sdram_ack,
   input  logic        sdram_rdy,
   input  logic [15:0] sdram_din
);

   typedef enum logic [1:0] {IDLE, REQ, WAIT0, WAIT1} state_t;

   state_t      state;
   logic [17:0] addr_q;
   logic        valid;
   logic [31:0] data_q;
   logic        hit;

   assign hit        = valid && (addr_q == rom_addr);
   assign rom_ok     = rom_cs && hit && (state == IDLE);
   assign rom_data   = data_q;
   // Address comes from the captured request, so it cannot move mid-fetch.
   assign sdram_addr = BASE + {4'd0, addr_q};

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         sdram_req <= 1'b0;
         valid     <= 1'b0;
         addr_q    <= 18'd0;
         data_q    <= 32'd0;
      end else begin
         case (state)
            IDLE: begin
               if (rom_cs && !hit) begin
                  addr_q    <= rom_addr;
                  valid     <= 1'b0;
                  sdram_req <= 1'b1;
                  state     <= REQ;
               end
            end
            REQ: begin
               if (sdram_ack) begin
                  sdram_req <= 1'b0;
                  state     <= WAIT0;
               end
            end
            WAIT0: begin
               if (sdram_rdy) begin
                  data_q[15:0] <= sdram_din;
                  state        <= WAIT1;
               end
            end
            WAIT1: begin
               if (sdram_rdy) begin
                  data_q[31:16] <= sdram_din;
                  valid         <= 1'b1;
                  state         <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
         // Without latching, a dropped chip select forgets the held word.
         if (!LATCH && !rom_cs)
            valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_jtbubl_rom_slot.sv
// Bench for jtbubl_rom_slot: SDRAM controller model plus an address/data
// scoreboard; a second instance exercises the BASE offset wrap.
module tb_jtbubl_rom_slot;

   logic        clk = 1'b0;
   logic        rst;
   logic        rom_cs;
   logic [17:0] rom_addr;
   logic [31:0] rom_data;
   logic        rom_ok;
   logic        sdram_req;
   logic [21:0] sdram_addr;
   logic        sdram_ack, sdram_rdy;
   logic [15:0] sdram_din;

   logic        ctl_ack, ctl_rdy, man_ack, man_rdy;
   logic [15:0] ctl_din, man_din;
   logic        ctl_en;
   int          ack_dly, rdy_gap, fetch_cnt;

   logic        rom_cs2;
   logic [17:0] rom_addr2;
   logic [31:0] rom_data2;
   logic        rom_ok2, sdram_req2;
   logic [21:0] sdram_addr2;
   logic        sdram_ack2, sdram_rdy2;
   logic [15:0] sdram_din2;

   int total = 0;
   int bad   = 0;

   logic [21:0] exp_addr_q[$];
   logic [31:0] exp_data_q[$];

   assign sdram_ack = ctl_ack | man_ack;
   assign sdram_rdy = ctl_rdy | man_rdy;
   assign sdram_din = ctl_din | man_din;

   always #5 clk = ~clk;

   jtbubl_rom_slot dut (
      .clk(clk), .rst(rst), .rom_cs(rom_cs), .rom_addr(rom_addr),
      .rom_data(rom_data), .rom_ok(rom_ok), .sdram_req(sdram_req),
      .sdram_addr(sdram_addr), .sdram_ack(sdram_ack), .sdram_rdy(sdram_rdy),
      .sdram_din(sdram_din)
   );

   jtbubl_rom_slot #(.BASE(22'h3FFFF0)) dut_wrap (
      .clk(clk), .rst(rst), .rom_cs(rom_cs2), .rom_addr(rom_addr2),
      .rom_data(rom_data2), .rom_ok(rom_ok2), .sdram_req(sdram_req2),
      .sdram_addr(sdram_addr2), .sdram_ack(sdram_ack2), .sdram_rdy(sdram_rdy2),
      .sdram_din(sdram_din2)
   );

   function automatic logic [15:0] mem_word(input logic [21:0] a);
      if (a == 22'h0000A0) return 16'h1234;
      if (a == 22'h0000A1) return 16'h5678;
      return a[15:0] ^ 16'hC3A5;
   endfunction

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end else begin
         $display("ok   %s: %h", tag, got);
      end
   endtask

   task automatic push_fetch(input logic [17:0] a, input bit expect_ok);
      logic [21:0] ea;
      ea = {4'd0, a};
      exp_addr_q.push_back(ea);
      if (expect_ok)
         exp_data_q.push_back({mem_word(ea + 22'd1), mem_word(ea)});
   endtask

   task automatic wait_ok(input string tag, input int max_cyc, output int lat);
      logic [31:0] exp;
      lat = 0;
      for (int i = 1; i <= max_cyc; i++) begin
         @(negedge clk);
         if (rom_ok) begin
            lat = i;
            break;
         end
      end
      if (lat == 0) begin
         check_val({tag, "_timeout"}, {31'd0, rom_ok}, 32'd1);
      end else begin
         check_val({tag, "_sb_pending"}, exp_data_q.size(), 32'd1);
         if (exp_data_q.size() > 0) begin
            exp = exp_data_q.pop_front();
            check_val({tag, "_data"}, rom_data, exp);
         end
      end
   endtask

   // SDRAM controller model: ack after ack_dly cycles, then two rdy pulses.
   initial begin
      logic [21:0] a;
      ctl_ack = 1'b0; ctl_rdy = 1'b0; ctl_din = 16'd0;
      forever begin
         @(negedge clk);
         if (ctl_en && sdram_req) begin
            a = sdram_addr;
            if (exp_addr_q.size() > 0)
               check_val("req_addr", {10'd0, a}, {10'd0, exp_addr_q.pop_front()});
            else
               check_val("req_unexpected", {31'd0, sdram_req}, 32'd0);
            repeat (ack_dly) @(negedge clk);
            ctl_ack = 1'b1;
            @(negedge clk);
            ctl_ack = 1'b0;
            check_val("req_drop", {31'd0, sdram_req}, 32'd0);
            repeat (rdy_gap) @(negedge clk);
            ctl_din = mem_word(a);
            ctl_rdy = 1'b1;
            @(negedge clk);
            ctl_rdy = 1'b0;
            ctl_din = 16'd0;
            check_val("no_overlap", {31'd0, sdram_req}, 32'd0);
            check_val("addr_stable", {10'd0, sdram_addr}, {10'd0, a});
            repeat (rdy_gap) @(negedge clk);
            ctl_din = mem_word(a + 22'd1);
            ctl_rdy = 1'b1;
            fetch_cnt++;
            @(negedge clk);
            ctl_rdy = 1'b0;
            ctl_din = 16'd0;
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int lat, start;
      logic [21:0] exp_wrap;
      rst = 1'b1; rom_cs = 1'b0; rom_addr = 18'd0;
      man_ack = 1'b0; man_rdy = 1'b0; man_din = 16'd0;
      ctl_en = 1'b1; ack_dly = 0; rdy_gap = 0; fetch_cnt = 0;
      rom_cs2 = 1'b0; rom_addr2 = 18'd0; sdram_ack2 = 1'b0; sdram_rdy2 = 1'b0; sdram_din2 = 16'd0;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      check_val("rst_ok", {31'd0, rom_ok}, 32'd0);
      check_val("rst_data", rom_data, 32'd0);
      check_val("rst_req", {31'd0, sdram_req}, 32'd0);

      // Miss with a slow ack
      ack_dly = 2;
      rom_addr = 18'h000A0;
      rom_cs = 1'b1;
      push_fetch(18'h000A0, 1'b1);
      wait_ok("miss", 30, lat);
      check_val("miss_data_lit", rom_data, 32'h56781234);

      // Held data reused after chip select gap
      rom_cs = 1'b0;
      repeat (5) @(negedge clk);
      rom_cs = 1'b1;
      #1;
      check_val("hit_same_cycle", {31'd0, rom_ok}, 32'd1);
      check_val("hit_data", rom_data, 32'h56781234);
      @(negedge clk);
      check_val("hit_no_req", {31'd0, sdram_req}, 32'd0);
      rom_cs = 1'b0;
      @(negedge clk);

      // Back-to-back misses with zero-wait controller
      ack_dly = 0; rdy_gap = 0;
      rom_addr = 18'h00200; rom_cs = 1'b1;
      push_fetch(18'h00200, 1'b1);
      wait_ok("b2b0", 20, lat);
      check_val("b2b0_latency", lat, 32'd4);
      rom_cs = 1'b0;
      @(negedge clk);
      rom_addr = 18'h00300; rom_cs = 1'b1;
      push_fetch(18'h00300, 1'b1);
      wait_ok("b2b1", 20, lat);
      check_val("b2b1_latency", lat, 32'd4);
      rom_cs = 1'b0;
      @(negedge clk);

      // Address moves while the first fetch sits in WAIT0
      ack_dly = 1; rdy_gap = 1;
      start = fetch_cnt;
      rom_addr = 18'h000A0; rom_cs = 1'b1;
      push_fetch(18'h000A0, 1'b0);
      push_fetch(18'h00100, 1'b1);
      repeat (3) @(negedge clk);
      rom_addr = 18'h00100;
      wait_ok("mid", 40, lat);
      check_val("mid_fetches", fetch_cnt - start, 32'd2);
      rom_cs = 1'b0;
      @(negedge clk);
      check_val("sb_addr_drained", exp_addr_q.size(), 32'd0);

      // BASE offset wraps modulo 2^22
      rom_addr2 = 18'h00020; rom_cs2 = 1'b1;
      exp_wrap = 22'h3FFFF0 + 22'h000020;
      @(negedge clk);
      check_val("wrap_req", {31'd0, sdram_req2}, 32'd1);
      check_val("wrap_addr", {10'd0, sdram_addr2}, {10'd0, exp_wrap});
      check_val("wrap_addr_lit", {10'd0, sdram_addr2}, 32'h000010);
      rom_cs2 = 1'b0;

      // Reset during WAIT1 abandons the fetch
      ctl_en = 1'b0;
      rom_addr = 18'h00400; rom_cs = 1'b1;
      @(negedge clk);
      check_val("rstm_req", {31'd0, sdram_req}, 32'd1);
      man_ack = 1'b1;
      @(negedge clk);
      man_ack = 1'b0;
      man_din = 16'hAAAA; man_rdy = 1'b1;
      @(negedge clk);
      man_rdy = 1'b0; man_din = 16'd0;
      rst = 1'b1; rom_cs = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      check_val("rstm_req_low", {31'd0, sdram_req}, 32'd0);
      check_val("rstm_ok", {31'd0, rom_ok}, 32'd0);
      check_val("rstm_data", rom_data, 32'd0);
      @(negedge clk);
      man_din = 16'hBEEF; man_rdy = 1'b1;
      @(negedge clk);
      man_rdy = 1'b0; man_din = 16'd0;
      @(negedge clk);
      check_val("stray_rdy_data", rom_data, 32'd0);
      check_val("stray_rdy_req", {31'd0, sdram_req}, 32'd0);
      rom_addr = 18'd0; rom_cs = 1'b1;
      #1;
      check_val("post_rst_miss", {31'd0, rom_ok}, 32'd0);
      rom_cs = 1'b0;
      @(negedge clk);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
